// File: rtl/upc_pkg.sv
// Shared types and defaults for the checkout scanner receive path.
package upc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int UPC_W_DEF        = 3;
    localparam int CLKS_PER_BIT_DEF = 4;

endpackage

// File: rtl/upc_sync2.sv
// Two-flop synchronizer for the raw scanner line. Both flops reset to 1
// so that a reset looks like an idle (high) line and never fakes a start bit.
module upc_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous line through two flops before anyone looks at it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/upc_scan_rx.sv
// Serial receiver for the checkout scanner line.
// Frame (idle high): start(0), data MSB first, parity, stop(1).
// Produces a held code plus one-cycle valid / parity error / framing error pulses.
// Optional feature: define UPC_FRAME_CNT_EN to add the 8-bit frame_cnt output,
// a wrapping count of good frames.
module upc_scan_rx
    import upc_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int UPC_W        = UPC_W_DEF,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_in,
    output logic [UPC_W-1:0] upc_q,
    output logic             upc_valid,
    output logic             parity_err,
    output logic             frame_err,
`ifdef UPC_FRAME_CNT_EN
    output logic             busy,
    output logic [7:0]       frame_cnt
`else
    output logic             busy
`endif
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (UPC_W > 1) ? $clog2(UPC_W) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UPC_W - 1);

    logic             s;
    rx_state_t        state_q;
    logic [TW-1:0]    tick_q;
    logic [BW-1:0]    bitIdx_q;
    logic [UPC_W-1:0] shiftReg_q;
    logic             parityBit_q;
    logic [UPC_W-1:0] code_q;
    logic             upcValid_q;
    logic             parityErr_q;
    logic             frameErr_q;
    logic             busy_q;
    logic             parityOk;
`ifdef UPC_FRAME_CNT_EN
    logic [7:0]       frameCnt_q;
`endif

    upc_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (scan_in),
        .sync_o  (s)
    );

    // Parity is judged over the received data plus the received parity bit.
    assign parityOk = ((^shiftReg_q) ^ parityBit_q) == PARITY_ODD;

    // Receive FSM: start validation, bit-centre sampling, result pulses and busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bitIdx_q    <= '0;
            shiftReg_q  <= '0;
            parityBit_q <= 1'b0;
            code_q      <= '0;
            upcValid_q  <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UPC_FRAME_CNT_EN
            frameCnt_q  <= '0;
`endif
        end else begin
            upcValid_q  <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!s) begin
                        state_q <= START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_q <= '0;
                        if (s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= DATA;
                            bitIdx_q <= '0;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q     <= '0;
                        shiftReg_q <= {shiftReg_q[UPC_W-2:0], s};
                        if (bitIdx_q == BIT_LAST) begin
                            state_q <= PARITY;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q      <= '0;
                        parityBit_q <= s;
                        state_q     <= STOP;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (!s) begin
                            frameErr_q <= 1'b1;
                            state_q    <= WAIT_IDLE;
                        end else if (parityOk) begin
                            code_q     <= shiftReg_q;
                            upcValid_q <= 1'b1;
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
`ifdef UPC_FRAME_CNT_EN
                            frameCnt_q <= frameCnt_q + 8'd1;
`endif
                        end else begin
                            parityErr_q <= 1'b1;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign upc_q      = code_q;
    assign upc_valid  = upcValid_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign busy       = busy_q;
`ifdef UPC_FRAME_CNT_EN
    assign frame_cnt  = frameCnt_q;
`endif

endmodule

// File: tb/tb_upc_scan_rx.sv
// Directed bench for upc_scan_rx at four clocks per bit, even parity.
// Frame counter output is exercised when UPC_FRAME_CNT_EN is defined.
module tb_upc_scan_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scan_in;
    logic [2:0] upc_q;
    logic       upc_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
`ifdef UPC_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int checkCount   = 0;
    int errorCount   = 0;
    int cyc          = 0;
    int validCount   = 0;
    int perrCount    = 0;
    int ferrCount    = 0;
    int multiCount   = 0;
    int lastValidCyc = 0;
    logic [2:0] codeQ[$];

    upc_scan_rx #(
        .CLKS_PER_BIT (CPB),
        .UPC_W        (3),
        .PARITY_ODD   (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_in    (scan_in),
        .upc_q      (upc_q),
        .upc_valid  (upc_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
`ifdef UPC_FRAME_CNT_EN
        .busy       (busy),
        .frame_cnt  (frame_cnt)
`else
        .busy       (busy)
`endif
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Cycle counter used to time the result pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (upc_valid) begin
            validCount++;
            lastValidCyc = cyc;
            codeQ.push_back(upc_q);
        end
        if (parity_err) perrCount++;
        if (frame_err) ferrCount++;
        if ((32'(upc_valid) + 32'(parity_err) + 32'(frame_err)) > 1) multiCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one serial bit starting at a falling clock edge.
    task automatic sendBit(input logic b);
        scan_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] code, input logic par, input logic stopBit);
        sendBit(1'b0);
        sendBit(code[2]);
        sendBit(code[1]);
        sendBit(code[0]);
        sendBit(par);
        sendBit(stopBit);
    endtask

    task automatic idle(input int n);
        scan_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int startCyc;
        int vBase;
        int pBase;
        int fBase;
        logic [2:0] cv;

        reset_n = 1'b0;
        scan_in = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_upc_q", 32'(upc_q), 32'h0);
        checkOutput("rst_valid", 32'(upc_valid), 32'h0);
        checkOutput("rst_perr", 32'(parity_err), 32'h0);
        checkOutput("rst_ferr", 32'(frame_err), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
`ifdef UPC_FRAME_CNT_EN
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'h0);
`endif
        reset_n = 1'b1;
        idle(4);

        $display("[TB] single frame 101");
        startCyc = cyc;
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("t1_busy_mid", 32'(busy), 32'h1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        idle(6);
        checkOutput("t1_valid_count", 32'(validCount), 32'd1);
        checkOutput("t1_latency", 32'(lastValidCyc - startCyc), 32'd25);
        checkOutput("t1_upc_q", 32'(upc_q), 32'h5);
        checkOutput("t1_busy_after", 32'(busy), 32'h0);
        idle(10);
        checkOutput("t1_upc_q_held", 32'(upc_q), 32'h5);

        $display("[TB] codes 0..7 back to back");
        codeQ.delete();
        vBase = validCount;
        for (int c = 0; c < 8; c++) begin
            cv = 3'(c);
            applyStimulus(cv, ^cv, 1'b1);
        end
        idle(6);
        checkOutput("t2_valid_count", 32'(validCount - vBase), 32'd8);
        checkOutput("t2_queue_size", 32'(codeQ.size()), 32'd8);
        if (codeQ.size() == 8) begin
            for (int c = 0; c < 8; c++) begin
                checkOutput($sformatf("t2_code%0d", c), 32'(codeQ[c]), 32'(c));
            end
        end
        checkOutput("t2_upc_q", 32'(upc_q), 32'h7);
        checkOutput("t2_perr_none", 32'(perrCount), 32'd0);
`ifdef UPC_FRAME_CNT_EN
        checkOutput("t2_frame_cnt", 32'(frame_cnt), 32'd9);
`endif

        $display("[TB] parity error on 110");
        vBase = validCount;
        applyStimulus(3'b110, 1'b1, 1'b1);
        idle(6);
        checkOutput("t3_perr_count", 32'(perrCount), 32'd1);
        checkOutput("t3_no_valid", 32'(validCount - vBase), 32'd0);
        checkOutput("t3_upc_q_kept", 32'(upc_q), 32'h7);
        checkOutput("t3_busy", 32'(busy), 32'h0);
`ifdef UPC_FRAME_CNT_EN
        checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd9);
`endif

        $display("[TB] framing error with stuck-low line");
        applyStimulus(3'b010, 1'b1, 1'b1);
        idle(4);
        checkOutput("t4_good_code", 32'(upc_q), 32'h2);
        vBase = validCount;
        pBase = perrCount;
        applyStimulus(3'b001, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("t4_ferr_count", 32'(ferrCount), 32'd1);
        checkOutput("t4_busy_wait_idle", 32'(busy), 32'h1);
        checkOutput("t4_upc_q_kept", 32'(upc_q), 32'h2);
        idle(30);
        checkOutput("t4_busy_released", 32'(busy), 32'h0);
        checkOutput("t4_no_new_valid", 32'(validCount - vBase), 32'd0);
        checkOutput("t4_no_new_perr", 32'(perrCount - pBase), 32'd0);
        checkOutput("t4_ferr_once", 32'(ferrCount), 32'd1);

        $display("[TB] one-cycle glitch");
        vBase = validCount;
        pBase = perrCount;
        fBase = ferrCount;
        scan_in = 1'b0;
        @(negedge clk);
        scan_in = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t5_busy_in_start", 32'(busy), 32'h1);
        idle(10);
        checkOutput("t5_busy_back", 32'(busy), 32'h0);
        checkOutput("t5_pulses",
                    32'((validCount - vBase) + (perrCount - pBase) + (ferrCount - fBase)), 32'd0);
        checkOutput("t5_upc_q_kept", 32'(upc_q), 32'h2);

        $display("[TB] reset during DATA");
        vBase = validCount;
        sendBit(1'b0);
        sendBit(1'b1);
        scan_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t6_busy_pre", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_upc_q", 32'(upc_q), 32'h0);
        checkOutput("t6_rst_busy", 32'(busy), 32'h0);
        checkOutput("t6_rst_pulses", 32'({upc_valid, parity_err, frame_err}), 32'h0);
`ifdef UPC_FRAME_CNT_EN
        checkOutput("t6_rst_frame_cnt", 32'(frame_cnt), 32'h0);
`endif
        @(negedge clk);
        scan_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        checkOutput("t6_no_partial_pulse", 32'(validCount - vBase), 32'd0);
        applyStimulus(3'b011, 1'b0, 1'b1);
        idle(6);
        checkOutput("t6_upc_q", 32'(upc_q), 32'h3);
        checkOutput("t6_valid_count", 32'(validCount - vBase), 32'd1);
`ifdef UPC_FRAME_CNT_EN
        checkOutput("t6_frame_cnt", 32'(frame_cnt), 32'd1);
`endif

        checkOutput("one_hot_pulses", 32'(multiCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
